pattern_event_logger: RTL

Downstream consumer of the serial pattern detector's 4-bit match code. It turns code changes into discrete match events and keeps a saturating hit counter per pattern (p1..p4). It also queues each event with a cycle timestamp in a small FIFO, which a host drains over a valid/ready handshake. Overflow of the queue is flagged and sticky until cleared.

---
 rtl/pattern_event_logger.sv | 121 ++++++++++++
 1 files changed

// File: rtl/pattern_event_logger.sv
// Match-code event logger: edge-detects pattern hits, keeps saturating
// per-pattern hit counters and queues timestamped events for a host.
module pattern_event_logger #(
  parameter int DEPTH = 4,
  parameter int TS_W  = 12,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       code_in,
  input  logic             clr,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [3:0]       evt_code,
  output logic [TS_W-1:0]  evt_ts,
  input  logic [1:0]       sel,
  output logic [CNT_W-1:0] count_out,
  output logic             ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [3:0]      code;
    logic [TS_W-1:0] ts;
  } entry_t;

  logic [3:0]       prev_q;
  logic [TS_W-1:0]  ts_q;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  entry_t           mem_q [DEPTH];
  logic [PW-1:0]    wp_q;
  logic [PW-1:0]    rp_q;
  logic [OW-1:0]    occ_q;
  logic [OW-1:0]    occ_d;
  logic             ovf_q;
  logic             ovf_d;

  logic       code_ok;
  logic       evt;
  logic       empty;
  logic       full;
  logic       pop;
  logic       push;
  logic       drop;
  logic [1:0] hit_idx;

  assign code_ok = (code_in != 4'd0) && (code_in <= 4'd4);
  assign evt     = code_ok && (code_in != prev_q);
  assign hit_idx = 2'(code_in - 4'd1);

  assign empty = (occ_q == '0);
  assign full  = (occ_q == OW'(DEPTH));
  assign pop   = !empty && evt_ready;
  // a pop in the same cycle frees the slot, so a full queue still accepts
  assign push  = evt && (!full || pop);
  assign drop  = evt && full && !pop;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      for (int i = 0; i < 4; i++) begin
        cnt_d[i] = '0;
      end
    end else if (evt && (cnt_q[hit_idx] != '1)) begin
      cnt_d[hit_idx] = cnt_q[hit_idx] + CNT_W'(1);
    end
  end

  always_comb begin
    occ_d = occ_q;
    unique case (1'b1)
      push && !pop: occ_d = occ_q + OW'(1);
      pop && !push: occ_d = occ_q - OW'(1);
      default:      occ_d = occ_q;
    endcase
  end

  assign ovf_d = clr ? 1'b0 : (ovf_q || drop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q <= '0;
      ts_q   <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      occ_q  <= '0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      prev_q <= code_in;
      ts_q   <= ts_q + TS_W'(1);
      occ_q  <= occ_d;
      ovf_q  <= ovf_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      if (push) begin
        mem_q[wp_q] <= '{code: code_in, ts: ts_q};
        wp_q        <= wp_q + PW'(1);
      end
      if (pop) begin
        rp_q <= rp_q + PW'(1);
      end
    end
  end

  assign evt_valid = !empty;
  assign evt_code  = empty ? 4'd0 : mem_q[rp_q].code;
  assign evt_ts    = empty ? '0 : mem_q[rp_q].ts;
  assign count_out = cnt_q[sel];
  assign ovf       = ovf_q;

endmodule
